// File: rtl/libar_key_unit_if.sv
// libar_key_unit_if: serial key-load handshake between a key source and libar_key_unit
interface libar_key_unit_if;
    logic load_start;
    logic key_in;
    logic key_valid;
    logic key_ready;
    modport master (output load_start, key_in, key_valid, input key_ready);
    modport slave (input load_start, key_in, key_valid, output key_ready);
endinterface

// File: rtl/libar_key_unit.sv
// libar_key_unit: serial key loader whose low NLIBAR key bits are latched into the
// locked netlist only when the matching trigger net rises while armed
module libar_key_unit #(
    parameter int NKEY = 32,
    parameter int NLIBAR = 12,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    libar_key_unit_if.slave kif,
    input  logic [NLIBAR-1:0] trig,
    input  logic rearm,
    output logic [NKEY-1:0] key_out,
    output logic [NLIBAR-1:0] libar_q,
    output logic [1:0] state,
    output logic key_loaded,
    output logic [CNT_W-1:0] cap_count
);
    localparam int IW = NKEY > 1 ? $clog2(NKEY) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ARMED = 2'd2, HOLD = 2'd3} state_t;
    state_t cur, nxt;
    logic [NKEY-1:0] key_sr;
    logic [IW-1:0] idx;
    logic [NLIBAR-1:0] mask, trig_d, cap;
    logic last_bit;
    assign cap = trig & ~trig_d & ~mask;
    assign last_bit = kif.key_valid && idx == IW'(NKEY - 1);
    assign state = cur;
    assign kif.key_ready = cur == LOAD;
    always_comb begin
        key_out = key_sr;
        key_out[NLIBAR-1:0] = libar_q;
    end
    always_comb begin
        nxt = cur;
        if (kif.load_start) nxt = LOAD;
        else case (cur)
            LOAD: nxt = last_bit ? ARMED : LOAD;
            ARMED: nxt = &(mask | cap) ? HOLD : ARMED;
            HOLD: nxt = rearm ? ARMED : HOLD;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else cur <= nxt;
    end
    // load_start wins over everything, so its clear branch comes first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sr <= '0;
            idx <= '0;
            libar_q <= '0;
            mask <= '0;
            trig_d <= '0;
            cap_count <= '0;
            key_loaded <= 1'b0;
        end else begin
            trig_d <= trig;
            if (kif.load_start) begin
                key_sr <= '0;
                idx <= '0;
                libar_q <= '0;
                mask <= '0;
                cap_count <= '0;
                key_loaded <= 1'b0;
            end else if (cur == LOAD && kif.key_valid) begin
                key_sr[idx] <= kif.key_in;
                idx <= idx + 1'b1;
                key_loaded <= last_bit;
            end else if (cur == HOLD && rearm) begin
                mask <= '0;
            end else if (cur == ARMED && |cap) begin
                libar_q <= (libar_q & ~cap) | (key_sr[NLIBAR-1:0] & cap);
                mask <= mask | cap;
                if (cap_count != '1) cap_count <= cap_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_libar_key_unit.sv
// tb_libar_key_unit: directed + randomized checks of libar_key_unit against a
// behavioural model built from accepted-bit queues and per-bit capture rules
module tb_libar_key_unit;
    localparam int NKEY = 32;
    localparam int NLIBAR = 12;
    localparam int CMAX = 255;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NLIBAR-1:0] trig = '0;
    logic rearm = 1'b0;
    logic [NKEY-1:0] key_out;
    logic [NLIBAR-1:0] libar_q;
    logic [1:0] state;
    logic key_loaded;
    logic [7:0] cap_count;
    libar_key_unit_if kif ();
    libar_key_unit #(.NKEY(NKEY), .NLIBAR(NLIBAR), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .kif(kif), .trig(trig), .rearm(rearm),
        .key_out(key_out), .libar_q(libar_q), .state(state),
        .key_loaded(key_loaded), .cap_count(cap_count)
    );
    always #5 clk = ~clk;
    int passed = 0;
    int total = 0;
    int ms;
    bit kq[$];
    bit [NLIBAR-1:0] mlq, mmask, mtd;
    int mcnt;
    bit mloaded;
    function automatic bit kbit(int i);
        return i < kq.size() ? kq[i] : 1'b0;
    endfunction
    function automatic logic [NKEY-1:0] exp_key();
        logic [NKEY-1:0] k;
        for (int i = 0; i < NKEY; i++) k[i] = i < NLIBAR ? mlq[i] : kbit(i);
        return k;
    endfunction
    task automatic model_reset();
        ms = 0;
        kq.delete();
        mlq = '0;
        mmask = '0;
        mtd = '0;
        mcnt = 0;
        mloaded = 1'b0;
    endtask
    task automatic model_step();
        bit [NLIBAR-1:0] rise;
        int n;
        rise = trig & ~mtd;
        mtd = trig;
        if (kif.load_start) begin
            ms = 1;
            kq.delete();
            mlq = '0;
            mmask = '0;
            mcnt = 0;
            mloaded = 1'b0;
        end else if (ms == 1) begin
            if (kif.key_valid) kq.push_back(kif.key_in);
            if (kq.size() == NKEY) begin
                ms = 2;
                mloaded = 1'b1;
            end
        end else if (ms == 3) begin
            if (rearm) begin
                ms = 2;
                mmask = '0;
            end
        end else if (ms == 2) begin
            n = 0;
            for (int i = 0; i < NLIBAR; i++)
                if (rise[i] && !mmask[i]) begin
                    mlq[i] = kbit(i);
                    mmask[i] = 1'b1;
                    n++;
                end
            if (n > 0 && mcnt < CMAX) mcnt++;
            if (&mmask) ms = 3;
        end
    endtask
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    task automatic check_all(string tag);
        chk({tag, ".state"}, 64'(state), 64'(ms));
        chk({tag, ".key_ready"}, 64'(kif.key_ready), 64'(ms == 1));
        chk({tag, ".key_loaded"}, 64'(key_loaded), 64'(mloaded));
        chk({tag, ".libar_q"}, 64'(libar_q), 64'(mlq));
        chk({tag, ".cap_count"}, 64'(cap_count), 64'(mcnt));
        chk({tag, ".key_out"}, 64'(key_out), 64'(exp_key()));
    endtask
    task automatic step(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask
    task automatic load_key(input logic [NKEY-1:0] k, input bit rnd_gaps, input int stop_at);
        int c = 0;
        kif.load_start = 1'b1;
        step("load_start");
        kif.load_start = 1'b0;
        while (kq.size() < stop_at) begin
            kif.key_valid = rnd_gaps ? 1'($urandom_range(0, 3) != 0) : 1'(c % 3 != 2);
            kif.key_in = k[kq.size()];
            trig = NLIBAR'($urandom);
            rearm = 1'($urandom);
            if (kq.size() == NKEY - 1) trig = '0;
            step("load");
            c++;
        end
        kif.key_valid = 1'b0;
        rearm = 1'b0;
    endtask
    initial begin
        kif.load_start = 1'b0;
        kif.key_in = 1'b0;
        kif.key_valid = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        chk("reset.key_out_zero", 64'(key_out), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            kif.key_valid = 1'($urandom);
            trig = NLIBAR'($urandom);
            rearm = 1'($urandom);
            step("idle");
        end
        load_key(32'hA5A5_0F0F, 1'b0, NKEY);
        chk("load.state_armed", 64'(state), 64'd2);
        chk("load.key_loaded", 64'(key_loaded), 64'd1);
        chk("load.key_out", 64'(key_out), 64'hA5A5_0000);
        trig = '0;
        step("armed_idle");
        for (int r = 0; r < 2; r++) begin
            trig = 12'h008;
            step("trig3_hi");
            trig = '0;
            step("trig3_lo");
        end
        chk("trig3.libar_q", 64'(libar_q), 64'h008);
        chk("trig3.cap_count", 64'(cap_count), 64'd1);
        trig = '1;
        step("trig_all");
        chk("trig_all.libar_q", 64'(libar_q), 64'hF0F);
        chk("trig_all.state_hold", 64'(state), 64'd3);
        chk("trig_all.key_out", 64'(key_out), 64'hA5A5_0F0F);
        for (int i = 0; i < 10; i++) begin
            trig = NLIBAR'($urandom);
            kif.key_valid = 1'($urandom);
            step("hold_toggle");
        end
        chk("hold.libar_q", 64'(libar_q), 64'hF0F);
        rearm = 1'b1;
        step("rearm");
        rearm = 1'b0;
        chk("rearm.state", 64'(state), 64'd2);
        chk("rearm.libar_q", 64'(libar_q), 64'hF0F);
        trig = '0;
        step("armed_after_rearm");
        kif.load_start = 1'b1;
        rearm = 1'b1;
        step("load_and_rearm");
        kif.load_start = 1'b0;
        rearm = 1'b0;
        chk("load_rearm.state", 64'(state), 64'd1);
        chk("load_rearm.key_out", 64'(key_out), 64'h0);
        load_key(NKEY'($urandom), 1'b1, NKEY);
        for (int i = 0; i < 300; i++) begin
            kif.load_start = 1'($urandom_range(0, 63) == 0);
            kif.key_valid = 1'($urandom);
            kif.key_in = 1'($urandom);
            rearm = 1'($urandom_range(0, 3) == 0);
            trig = NLIBAR'($urandom) & NLIBAR'($urandom);
            step("random");
        end
        kif.load_start = 1'b0;
        rearm = 1'b0;
        load_key(NKEY'($urandom), 1'b1, NKEY);
        for (int i = 0; i < 260; i++) begin
            trig = '0;
            step("sat_lo");
            trig = '1;
            step("sat_hi");
            rearm = 1'b1;
            step("sat_rearm");
            rearm = 1'b0;
        end
        chk("sat.cap_count", 64'(cap_count), 64'd255);
        load_key(NKEY'($urandom), 1'b0, 17);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_reset.state", 64'(state), 64'd0);
        @(negedge clk);
        step("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        trig = '0;
        step("post_reset");
        load_key(32'h1234_5678, 1'b0, NKEY);
        chk("reload.key_loaded", 64'(key_loaded), 64'd1);
        chk("reload.key_out", 64'(key_out), 64'h1234_5000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
